// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage widths, reset PC, next-PC select and HLT opcode
package fetch_pkg;
    localparam int ADDR_W_DEF = 11;
    localparam int CNT_W_DEF  = 16;
    localparam int RST_PC_DEF = 0;
    localparam logic [3:0] OP_HLT = 4'hF;
    typedef enum logic [1:0] {NPC_HOLD, NPC_INC, NPC_REDIR} npc_sel_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] r_cnt;
    assign cnt = r_cnt;
    // clear wins over increment; stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) r_cnt <= '0;
        else if (inc && r_cnt != '1) r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: program counter, IM read control, ID alignment, halt and fetch statistics
module if_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int RST_PC = RST_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_IF,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_tgt,
    input  logic              hlt_ID,
    input  logic              stats_clr,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] pc_ID,
    output logic              instr_vld_ID,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  redir_cnt
);
    logic [ADDR_W-1:0] r_pc, r_pc_id;
    logic              r_vld, r_halted;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_rd_en, w_take_hlt, w_take_redir;
    npc_sel_e          w_npc_sel;

    assign w_pc_inc     = r_pc + ADDR_W'(1);
    assign w_rd_en      = !stall_IF && !r_halted;
    assign w_take_hlt   = w_rd_en && hlt_ID && r_vld;
    assign w_take_redir = w_rd_en && redirect && r_vld && !hlt_ID;

    assign addr         = r_pc;
    assign rd_en        = w_rd_en;
    assign pc_ID        = r_pc_id;
    assign instr_vld_ID = r_vld;
    assign halted       = r_halted;

    // next-PC select: hold on stall/halt, jump on accepted redirect, else increment
    always_comb begin
        w_npc_sel = NPC_INC;
        if (!w_rd_en || w_take_hlt) w_npc_sel = NPC_HOLD;
        else if (w_take_redir) w_npc_sel = NPC_REDIR;
    end

    // PC, ID-alignment and halt state; ID side only moves when the IM actually reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= ADDR_W'(RST_PC);
            r_pc_id  <= '0;
            r_vld    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_pc <= (w_npc_sel == NPC_REDIR) ? redirect_tgt :
                    (w_npc_sel == NPC_INC)   ? w_pc_inc     : r_pc;
            if (w_take_hlt) r_halted <= 1'b1;
            if (w_rd_en) begin
                r_pc_id <= w_pc_inc;
                r_vld   <= !w_take_redir;
            end else if (r_halted) begin
                r_vld <= 1'b0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk(clk), .rst(rst), .inc(w_rd_en && !w_take_redir), .clr(stats_clr), .cnt(fetch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk(clk), .rst(rst), .inc(w_take_redir), .clr(stats_clr), .cnt(redir_cnt)
    );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: randomized + directed scoreboard bench for the fetch control stage
module tb_if_fetch_ctrl;
    localparam int AW = 11;
    localparam int CW = 16;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rd_en;
        logic [AW-1:0] pc_id;
        logic          vld;
        logic          halted;
        int            fc;
        int            rc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall_IF = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_tgt = '0;
    logic          hlt_ID = 1'b0;
    logic          stats_clr = 1'b0;
    logic [AW-1:0] addr, pc_ID;
    logic          rd_en, instr_vld_ID, halted;
    logic [CW-1:0] fetch_cnt, redir_cnt;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    // reference state
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] m_pcid = '0;
    logic          m_vld = 1'b0;
    logic          m_halt = 1'b0;
    int            m_fc = 0;
    int            m_rc = 0;

    if_fetch_ctrl #(.ADDR_W(AW), .CNT_W(CW), .RST_PC(0)) dut (
        .clk(clk), .rst(rst), .stall_IF(stall_IF), .redirect(redirect),
        .redirect_tgt(redirect_tgt), .hlt_ID(hlt_ID), .stats_clr(stats_clr),
        .addr(addr), .rd_en(rd_en), .pc_ID(pc_ID), .instr_vld_ID(instr_vld_ID),
        .halted(halted), .fetch_cnt(fetch_cnt), .redir_cnt(redir_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // one clock of stimulus: drive at negedge, advance the model, queue the expected post-edge view
    task automatic cycle(input logic r, input logic st, input logic rd, input logic [AW-1:0] tg,
                         input logic h, input logic c);
        exp_t e;
        logic live;
        @(negedge clk);
        rst = r; stall_IF = st; redirect = rd; redirect_tgt = tg; hlt_ID = h; stats_clr = c;
        live = !st && !m_halt;
        if (r) begin
            m_pc = '0; m_pcid = '0; m_vld = 1'b0; m_halt = 1'b0; m_fc = 0; m_rc = 0;
        end else begin
            if (m_halt) m_vld = 1'b0;
            else if (live && h && m_vld) begin
                m_halt = 1'b1; m_pcid = m_pc + 1'b1; m_vld = 1'b1; m_fc = m_fc + 1;
            end else if (live && rd && m_vld) begin
                m_pcid = m_pc + 1'b1; m_pc = tg; m_vld = 1'b0; m_rc = m_rc + 1;
            end else if (live) begin
                m_pcid = m_pc + 1'b1; m_pc = m_pc + 1'b1; m_vld = 1'b1; m_fc = m_fc + 1;
            end
            if (m_fc > CMAX) m_fc = CMAX;
            if (m_rc > CMAX) m_rc = CMAX;
            if (c) begin m_fc = 0; m_rc = 0; end
        end
        e.addr = m_pc; e.rd_en = !st && !m_halt; e.pc_id = m_pcid; e.vld = m_vld;
        e.halted = m_halt; e.fc = m_fc; e.rc = m_rc;
        q.push_back(e);
    endtask

    // monitor: compare every post-edge view of the DUT against the next queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("addr", int'(addr), int'(e.addr));
                chk("rd_en", int'(rd_en), int'(e.rd_en));
                chk("pc_ID", int'(pc_ID), int'(e.pc_id));
                chk("instr_vld_ID", int'(instr_vld_ID), int'(e.vld));
                chk("halted", int'(halted), int'(e.halted));
                chk("fetch_cnt", int'(fetch_cnt), e.fc);
                chk("redir_cnt", int'(redir_cnt), e.rc);
            end
        end
    end

    initial begin
        // reset then free-run five cycles
        cycle(1, 0, 0, '0, 0, 0);
        repeat (5) cycle(0, 0, 0, '0, 0, 0);
        // redirect to 0x100, then run past the bubble
        cycle(0, 0, 1, 11'h100, 0, 0);
        repeat (3) cycle(0, 0, 0, '0, 0, 0);
        // three stall cycles, redirect in the middle one
        cycle(0, 1, 0, '0, 0, 0);
        cycle(0, 1, 1, 11'h055, 0, 0);
        cycle(0, 1, 0, '0, 0, 0);
        repeat (2) cycle(0, 0, 0, '0, 0, 0);
        // redirect to the top address and wrap
        cycle(0, 0, 1, 11'h7FF, 0, 0);
        repeat (3) cycle(0, 0, 0, '0, 0, 0);
        // halt together with redirect, stay halted, then reset
        cycle(0, 0, 1, 11'h123, 1, 0);
        repeat (3) cycle(0, 0, 1, 11'h123, 1, 0);
        cycle(1, 0, 0, '0, 0, 0);
        repeat (2) cycle(0, 0, 0, '0, 0, 0);
        // randomized traffic with occasional resets, clears and halts
        for (int i = 0; i < 2000; i++) begin
            logic r;
            r = ($urandom_range(0, 59) == 0) || (m_halt && $urandom_range(0, 4) == 0);
            cycle(r, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  AW'($urandom_range(0, (1 << AW) - 1)), $urandom_range(0, 79) == 0,
                  $urandom_range(0, 39) == 0);
        end
        // saturate fetch_cnt by free-running past 2^CW-1 deliveries
        cycle(1, 0, 0, '0, 0, 0);
        repeat (CMAX + 3) cycle(0, 0, 0, '0, 0, 0);
        // clear coinciding with an increment
        cycle(0, 0, 0, '0, 0, 1);
        repeat (2) cycle(0, 0, 0, '0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
